// File: rtl/div_core.sv
// Self-starting restoring unsigned divider: one quotient bit per clock.
// The result is recomputed whenever the operands differ from the latched pair.
module div_core #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic             ready
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_r, a_s, b_r, b_s;
    logic [WIDTH-1:0] rem_r, rem_s, quo_r, quo_s;
    logic [WIDTH-1:0] o0_s, o1_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             ready_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH-1:0] diff_s, rem_step_s, quo_step_s;
    logic             ge_s;

    // One restoring step; the extra shift bit keeps the compare exact, and
    // the subtraction only needs WIDTH bits because the result is below b.
    always_comb begin
        shift_s    = {rem_r, quo_r[WIDTH-1]};
        ge_s       = (shift_s >= {1'b0, b_r});
        diff_s     = shift_s[WIDTH-1:0] - b_r;
        quo_step_s = {quo_r[WIDTH-2:0], ge_s};
        if (ge_s) begin
            rem_step_s = diff_s;
        end else begin
            rem_step_s = shift_s[WIDTH-1:0];
        end
    end

    // Next-state and next-register logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        rem_s   = rem_r;
        quo_s   = quo_r;
        cnt_s   = cnt_r;
        o0_s    = o0;
        o1_s    = o1;
        ready_s = ready;
        case (state_r)
            IDLE: begin
                a_s     = i0;
                b_s     = i1;
                rem_s   = '0;
                quo_s   = i0;
                cnt_s   = CNT_LAST;
                ready_s = 1'b0;
                state_s = CALC;
            end
            CALC: begin
                rem_s = rem_step_s;
                quo_s = quo_step_s;
                cnt_s = cnt_r - CW'(1);
                if (cnt_r == '0) begin
                    o0_s    = quo_step_s;
                    o1_s    = rem_step_s;
                    ready_s = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if ((i0 != a_r) || (i1 != b_r)) begin
                    a_s     = i0;
                    b_s     = i1;
                    rem_s   = '0;
                    quo_s   = i0;
                    cnt_s   = CNT_LAST;
                    ready_s = 1'b0;
                    state_s = CALC;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                ready_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            cnt_r   <= '0;
            o0      <= '0;
            o1      <= '0;
            ready   <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            rem_r   <= rem_s;
            quo_r   <= quo_s;
            cnt_r   <= cnt_s;
            o0      <= o0_s;
            o1      <= o1_s;
            ready   <= ready_s;
        end
    end
endmodule

// File: tb/tb_div_core.sv
// Directed and randomized checks of div_core against an arithmetic reference
// built from plain / and %, with divide-by-zero giving all ones and the dividend.
module tb_div_core;
    localparam int W = 16;

    logic         clock;
    logic         reset_n;
    logic [W-1:0] i0, i1;
    logic [W-1:0] o0, o1;
    logic         ready;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_q, prev_r;

    div_core #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .i0     (i0),
        .i1     (i1),
        .o0     (o0),
        .o1     (o1),
        .ready  (ready)
    );

    // Rising edges at 15, 35, 55 ns ...; outputs are sampled on falling edges.
    initial begin
        clock = 1'b0;
        #5;
        forever #10 clock = ~clock;
    end

    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {{W{1'b1}}, a};
        return {a / b, a % b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts falling edges until ready is seen high or the budget runs out.
    task automatic wait_ready(input int budget, output int edges);
        edges = 0;
        do begin
            @(negedge clock);
            edges++;
        end while (ready !== 1'b1 && edges < budget);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] e;
        e = ref_div(a, b);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_quo"}, {16'd0, o0}, {16'd0, e[2*W-1:W]});
        check({tag, "_rem"}, {16'd0, o1}, {16'd0, e[W-1:0]});
        prev_q = e[2*W-1:W];
        prev_r = e[W-1:0];
    endtask

    // Restart from DONE: ready drops on the next edge, old result is held,
    // and the new result appears 16 edges after that.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        i0 = a;
        i1 = b;
        @(negedge clock);
        check({tag, "_drop"}, {31'd0, ready}, 32'd0);
        check({tag, "_hold_q"}, {16'd0, o0}, {16'd0, prev_q});
        check({tag, "_hold_r"}, {16'd0, o1}, {16'd0, prev_r});
        wait_ready(40, n);
        check({tag, "_lat"}, n, 32'd16);
        check_result(tag, a, b);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        reset_n = 1'b0;
        i0 = 16'hB0B0;
        i1 = 16'h029A;
        prev_q = '0;
        prev_r = '0;

        #5;
        check("rst_quo", {16'd0, o0}, 32'd0);
        check("rst_rem", {16'd0, o1}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);

        #45 reset_n = 1'b1;
        wait_ready(40, n);
        check("first_lat", n, 32'd17);
        check_result("b0b0", 16'hB0B0, 16'h029A);
        check("b0b0_q_const", {16'd0, o0}, 32'h0043);
        check("b0b0_r_const", {16'd0, o1}, 32'h0262);
        repeat (3) @(negedge clock);
        check("b0b0_stay", {31'd0, ready}, 32'd1);
        check("b0b0_stable", {16'd0, o0}, 32'h0043);

        do_op("d100_7", 16'd100, 16'd7);
        check("d100_7_const", {o0, o1}, {16'd14, 16'd2});
        do_op("a_lt_b", 16'h0005, 16'h0007);
        do_op("div_one", 16'hFFFF, 16'h0001);
        do_op("div_zero", 16'h1234, 16'h0000);
        do_op("zero_zero", 16'h0000, 16'h0000);
        do_op("eq", 16'h8001, 16'h8001);

        for (int k = 0; k < 10; k++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            if (ra == i0 && rb == i1) ra = ra + 16'd1;
            do_op("rand", ra, rb);
        end

        // Short reset pulse between edges during a computation.
        i0 = 16'hABCD;
        i1 = 16'h0012;
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_quo", {16'd0, o0}, 32'd0);
        check("midrst_rem", {16'd0, o1}, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd0);
        #4 reset_n = 1'b1;
        wait_ready(40, n);
        check("midrst_lat", n, 32'd17);
        check_result("midrst", 16'hABCD, 16'h0012);

        // Dividend changes mid-computation: latched operands win, then recompute.
        i0 = 16'd1000;
        i1 = 16'd33;
        repeat (4) @(negedge clock);
        i0 = 16'd50000;
        wait_ready(40, n);
        check("chg_lat", n, 32'd13);
        check_result("chg_old", 16'd1000, 16'd33);
        @(negedge clock);
        check("chg_redo", {31'd0, ready}, 32'd0);
        check("chg_hold", {16'd0, o0}, {16'd0, prev_q});
        wait_ready(40, n);
        check("chg_lat2", n, 32'd16);
        check_result("chg_new", 16'd50000, 16'd33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
